// File: rtl/tdm_demux4_if.sv
// Bus bundle for the 4-channel TDM demultiplexer: serial line in, channel slots and status out.
// TDM_SYNC_CHECK_EN adds the sync_err status line.
interface tdm_demux4_if #(
    parameter int unsigned WIDTH = 1
);
    logic             en;
    logic [WIDTH-1:0] w;
    logic             frame_sync;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             s1;
    logic             s0;
    logic             locked;
    logic             frame_done;
`ifdef TDM_SYNC_CHECK_EN
    logic             sync_err;
`endif

    modport master (
        output en, w, frame_sync,
`ifdef TDM_SYNC_CHECK_EN
        input  sync_err,
`endif
        input  a, b, c, d, s1, s0, locked, frame_done
    );

    modport slave (
        input  en, w, frame_sync,
`ifdef TDM_SYNC_CHECK_EN
        output sync_err,
`endif
        output a, b, c, d, s1, s0, locked, frame_done
    );
endinterface

// File: rtl/tdm_demux4.sv
// 4-channel TDM demultiplexer: steers serial samples into slots a..d, publishing whole frames atomically.
// Optional TDM_SYNC_CHECK_EN: sync_err reporting and drop to HUNT after three consecutive sync errors.
module tdm_demux4 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    tdm_demux4_if.slave  bus
);
    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic             frame_done_q, frame_done_d;
    logic             drop_c;

`ifdef TDM_SYNC_CHECK_EN
    logic [1:0] err_cnt_q, err_cnt_d;
    logic       sync_err_q, sync_err_d;
    logic       err_c;

    // Sync error: pulse where none is due, or missing pulse at slot 0.
    always_comb begin
        err_c  = (state_q == LOCKED) && bus.en &&
                 (bus.frame_sync ? (cnt_q != 2'd0) : (cnt_q == 2'd0));
        drop_c = err_c && (err_cnt_q == 2'd2);
    end
`else
    assign drop_c = 1'b0;
`endif

    // State register plus all datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            cnt_q        <= 2'd0;
            sh0_q        <= '0;
            sh1_q        <= '0;
            sh2_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            d_q          <= '0;
            frame_done_q <= 1'b0;
`ifdef TDM_SYNC_CHECK_EN
            err_cnt_q    <= 2'd0;
            sync_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh0_q        <= sh0_d;
            sh1_q        <= sh1_d;
            sh2_q        <= sh2_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            d_q          <= d_d;
            frame_done_q <= frame_done_d;
`ifdef TDM_SYNC_CHECK_EN
            err_cnt_q    <= err_cnt_d;
            sync_err_q   <= sync_err_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HUNT:    if (bus.en && bus.frame_sync) state_d = LOCKED;
            LOCKED:  if (drop_c)                   state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    // Slot capture, frame publish and error tracking.
    always_comb begin
        cnt_d        = cnt_q;
        sh0_d        = sh0_q;
        sh1_d        = sh1_q;
        sh2_d        = sh2_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        d_d          = d_q;
        frame_done_d = 1'b0;
`ifdef TDM_SYNC_CHECK_EN
        err_cnt_d    = err_cnt_q;
        sync_err_d   = err_c;
        if (err_c)
            err_cnt_d = drop_c ? 2'd0 : err_cnt_q + 2'd1;
        else if (bus.en && bus.frame_sync)
            err_cnt_d = 2'd0;
`endif
        if (bus.en) begin
            if (drop_c) begin
                cnt_d = 2'd0;
            end else if (bus.frame_sync) begin
                sh0_d = bus.w;
                cnt_d = 2'd1;
            end else if (state_q == LOCKED) begin
                cnt_d = cnt_q + 2'd1;
                unique case (cnt_q)
                    2'd0: sh0_d = bus.w;
                    2'd1: sh1_d = bus.w;
                    2'd2: sh2_d = bus.w;
                    default: begin
                        a_d          = sh0_q;
                        b_d          = sh1_q;
                        c_d          = sh2_q;
                        d_d          = bus.w;
                        frame_done_d = 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.a          = a_q;
    assign bus.b          = b_q;
    assign bus.c          = c_q;
    assign bus.d          = d_q;
    assign bus.s1         = cnt_q[1];
    assign bus.s0         = cnt_q[0];
    assign bus.locked     = (state_q == LOCKED);
    assign bus.frame_done = frame_done_q;
`ifdef TDM_SYNC_CHECK_EN
    assign bus.sync_err   = sync_err_q;
`endif
endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 (WIDTH=1), including TDM_SYNC_CHECK_EN behaviour when defined.
module tb_tdm_demux4;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    tdm_demux4_if #(.WIDTH(1)) bus ();
    tdm_demux4 #(.WIDTH(1)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] abcd();
        return {bus.a[0], bus.b[0], bus.c[0], bus.d[0]};
    endfunction

    // Drive at negedge, let one posedge pass, return at the following negedge.
    task automatic step(input logic e, input logic wv, input logic fs);
        bus.en = e; bus.w = wv; bus.frame_sync = fs;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) step(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        check("rst_abcd", 32'(abcd()), 32'h0);
        check("rst_locked", 32'(bus.locked), 32'h0);
        check("rst_slot", 32'({bus.s1, bus.s0}), 32'h0);
        check("rst_done", 32'(bus.frame_done), 32'h0);
    endtask

    // Contiguous synced frame; bits[3] is slot 0. Outputs must hold prev until the last sample.
    task automatic frame(input logic [3:0] bits, input logic [3:0] prev);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bits[3-i], i == 0);
            if (i < 3) begin
                check("frm_hold", 32'(abcd()), 32'(prev));
                check("frm_nodone", 32'(bus.frame_done), 32'h0);
            end
        end
        check("frm_data", 32'(abcd()), 32'(bits));
        check("frm_done", 32'(bus.frame_done), 32'h1);
    endtask

    int pulses;

    initial begin
        rst = 1'b0; bus.en = 1'b0; bus.w = 1'b0; bus.frame_sync = 1'b0;
        @(negedge clk);

        // 1: reset then lock, slot sequence 01,10,11,00
        do_reset(2);
        step(1'b1, 1'b1, 1'b1);
        check("t1_locked", 32'(bus.locked), 32'h1);
        check("t1_s01", 32'({bus.s1, bus.s0}), 32'h1);
        step(1'b1, 1'b0, 1'b0);
        check("t1_s10", 32'({bus.s1, bus.s0}), 32'h2);
        step(1'b1, 1'b0, 1'b0);
        check("t1_s11", 32'({bus.s1, bus.s0}), 32'h3);
        check("t1_hold", 32'(abcd()), 32'h0);
        step(1'b1, 1'b0, 1'b0);
        check("t1_s00", 32'({bus.s1, bus.s0}), 32'h0);
        check("t1_data", 32'(abcd()), 32'h8);
        check("t1_done", 32'(bus.frame_done), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        check("t1_pulse", 32'(bus.frame_done), 32'h0);

        // 2: streaming frames back to back
        frame(4'b1011, 4'b1000);
        frame(4'b0111, 4'b1011);

        // 3: hunt discards unsynced samples
        do_reset(1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        check("t3_abcd", 32'(abcd()), 32'h0);
        check("t3_locked", 32'(bus.locked), 32'h0);
        check("t3_slot", 32'({bus.s1, bus.s0}), 32'h0);
        frame(4'b0100, 4'b0000);

        // 4: enable gaps between every sample
        begin
            logic [3:0] fb;
            fb = 4'b1101;
            for (int i = 0; i < 4; i++) begin
                step(1'b1, fb[3-i], i == 0);
                step(1'b0, ~fb[3-i], 1'b1);
                check("t4_slot", 32'({bus.s1, bus.s0}), 32'((i + 1) % 4));
                check("t4_gapdone", 32'(bus.frame_done), 32'h0);
            end
            check("t4_data", 32'(abcd()), 32'hD);
        end

        // 5: early resync abandons the partial frame
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        check("t5_s10", 32'({bus.s1, bus.s0}), 32'h2);
        step(1'b1, 1'b0, 1'b1);
        check("t5_resync", 32'({bus.s1, bus.s0}), 32'h1);
        check("t5_hold", 32'(abcd()), 32'hD);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("t5_nodone", 32'(bus.frame_done), 32'h0);
        check("t5_hold2", 32'(abcd()), 32'hD);
        step(1'b1, 1'b1, 1'b0);
        check("t5_data", 32'(abcd()), 32'h7);
        check("t5_done", 32'(bus.frame_done), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        check("t5_pulse", 32'(bus.frame_done), 32'h0);

        // 6: reset mid-frame, then a fresh aligned frame
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        do_reset(1);
        frame(4'b0010, 4'b0000);

        // Frames without sync pulses
        frame(4'b1111, 4'b0010);
        pulses = 0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 4; i++) begin
                step(1'b1, (i % 2) == 0, 1'b0);
`ifdef TDM_SYNC_CHECK_EN
                if (bus.sync_err) pulses++;
`endif
            end
        end
`ifdef TDM_SYNC_CHECK_EN
        check("t6_errpulses", 32'(pulses), 32'h3);
        check("t6_dropped", 32'(bus.locked), 32'h0);
        check("t6_slot", 32'({bus.s1, bus.s0}), 32'h0);
        check("t6_abcd", 32'(abcd()), 32'hA);
        step(1'b0, 1'b0, 1'b0);
        check("t6_errclr", 32'(bus.sync_err), 32'h0);
`else
        check("t6_stays", 32'(bus.locked), 32'h1);
        check("t6_abcd", 32'(abcd()), 32'hA);
        check("t6_done", 32'(bus.frame_done), 32'h1);
        check("t6_pulses", 32'(pulses), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive-side counterpart of the 4:1 selector used on the shared line: a 4-channel time-division demultiplexer.
- Samples a single serial data line on every enabled clock and steers each sample into one of four channel slots (a, b, c, d) using an internal 2-bit slot counter (s1,s0).
- Slot 0 is aligned by a frame-sync pulse.
- Complete frames are published atomically on registered outputs with a done strobe.

Parameters:
- WIDTH, 1, bit width of the line and of each channel output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  slot-advance enable; w is sampled only on cycles with en=1.
- w  input  WIDTH  shared serial line (mux output).
- frame_sync  input  1  marks the sample on w as slot 0; meaningful only when en=1.
- a  output  WIDTH  channel 0 data, registered, held between frames.
- b  output  WIDTH  channel 1 data.
- c  output  WIDTH  channel 2 data.
- d  output  WIDTH  channel 3 data.
- s1  output  1  current slot counter MSB.
- s0  output  1  current slot counter LSB.
- locked  output  1  1 while frame-aligned.
- frame_done  output  1  one-cycle pulse when a,b,c,d have just been updated.

Behaviour:
- Reset (rst=1 at a clk edge) clears the following, and overrides all other inputs on that edge:
  - a, b, c, d, s1, s0, locked, frame_done and shadow registers all go to 0.
  - FSM goes to HUNT.
- Two-state FSM: HUNT and LOCKED.
- HUNT:
  - Samples with en=1 and frame_sync=0 are discarded; counter stays 0.
  - en=1 with frame_sync=1: capture w into shadow slot 0, counter goes to 1, go to LOCKED.
- LOCKED, en=1, frame_sync=0:
  - Capture w into shadow[{s1,s0}].
  - Counter increments mod 4 (3 wraps to 0).
- LOCKED, en=1, frame_sync=1:
  - Capture w into shadow slot 0 and set the counter to 1 (resync).
  - Any partial frame is abandoned: no frame_done and no output update for it.
  - When the counter is already 0, a resync behaves identically to a normal slot-0 capture.
- en=0: no capture, counter held, state held, frame_done=0.
- Frame completion:
  - On the edge that captures slot 3 while LOCKED, the slot-3 sample goes directly to d.
  - Shadow slots 0..2 are copied to a, b, c on the same edge.
  - frame_done=1 for the following cycle only.
  - Latency: new outputs are visible one clock after the slot-3 sample edge.
- a..d change only on frame completion or reset; they never show a mixed old/new frame.
- locked follows the FSM state (registered).
- s1,s0 give the slot to be captured on the next enabled edge.
- Back-to-back frames with en held high produce frame_done every 4 cycles, with no bubble.

Optional Feature:
- Macro: TDM_SYNC_CHECK_EN.
- Defined:
  - Adds output sync_err (1 bit, reset 0).
  - sync_err pulses for one cycle after any LOCKED, en=1 edge where one of these holds:
    - frame_sync=1 with counter≠0, or
    - frame_sync=0 with counter=0.
  - On three consecutive sync errors the FSM drops to HUNT: locked goes to 0, the counter clears and the partial frame is discarded.
- Undefined:
  - No sync_err port.
  - Missing or early sync pulses only resync as described in Behaviour; the FSM never leaves LOCKED except on reset.

Test Plan:
1. Reset then lock: rst=1 two cycles, then en=1, WIDTH=1, frame_sync on first sample, w=1,0,0,0 → a=1 b=0 c=0 d=0 one cycle after 4th sample; frame_done single pulse; locked=1 after first sample; s1,s0 sequence 01,10,11,00.
2. Streaming frames: w=1,0,1,1 then 0,1,1,1 with en held and sync each 4th cycle → outputs 1,0,1,1 then 0,1,1,1; frame_done every 4 cycles; outputs stable between pulses.
3. Hunt discard: en=1, w=1 for 3 cycles without sync → a..d=0, locked=0, s1,s0=00; then sync frame w=0,1,0,0 → b=1 only.
4. Enable gaps: frame 1,1,0,1 with en=0 inserted between every sample → same result as contiguous; counter frozen during gaps; frame_done exactly once.
5. Early resync: after 2 samples (1,1), frame_sync with w=0, then 1,1,1 → a=0 b=1 c=1 d=1; only one frame_done; old partial frame never visible.
6. Reset mid-frame: rst=1 after slot 1 capture → all outputs 0, locked=0; a later aligned frame 0,0,1,0 → c=1. With TDM_SYNC_CHECK_EN: three frames missing sync → sync_err pulses 3 times, locked=0.
